// File: rtl/region_restore_engine.sv
// region_restore_engine: redraws a W x H screen rectangle into the VGA
// plot port, from background RAM (mode 0) or as a solid fill (mode 1).
// Ports: i_clk, i_reset (sync, active high); i_start/i_mode/i_org_x/
//  i_org_y/i_rect_w/i_rect_h/i_fill_colour request; o_bg_addr/i_bg_q
//  background RAM read; o_busy/o_done handshake; o_vga_x/o_vga_y/
//  o_vga_colour/o_vga_plot VGA adapter write port.
`timescale 1ns/1ps
module region_restore_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15,
  parameter int MAX_W    = 32,
  parameter int MAX_H    = 32,
  parameter int RD_LAT   = 2,
  localparam int WW = $clog2(MAX_W + 1),
  localparam int HW = $clog2(MAX_H + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_mode,
  input  logic [X_W-1:0]      i_org_x,
  input  logic [Y_W-1:0]      i_org_y,
  input  logic [WW-1:0]       i_rect_w,
  input  logic [HW-1:0]       i_rect_h,
  input  logic [COLOUR_W-1:0] i_fill_colour,
  output logic [ADDR_W-1:0]   o_bg_addr,
  input  logic [COLOUR_W-1:0] i_bg_q,
  output logic                o_busy,
  output logic                o_done,
  output logic [X_W-1:0]      o_vga_x,
  output logic [Y_W-1:0]      o_vga_y,
  output logic [COLOUR_W-1:0] o_vga_colour,
  output logic                o_vga_plot
);

  localparam int DW = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                r_mode;
  logic [X_W-1:0]      r_org_x;
  logic [Y_W-1:0]      r_org_y;
  logic [WW-1:0]       r_w;
  logic [HW-1:0]       r_h;
  logic [COLOUR_W-1:0] r_fill;
  logic [WW-1:0]       r_cx;
  logic [HW-1:0]       r_cy;
  logic [DW-1:0]       r_dcnt;

  logic [X_W-1:0] r_dx [RD_LAT];
  logic [Y_W-1:0] r_dy [RD_LAT];
  logic           r_dv [RD_LAT];

  logic           w_accept;
  logic           w_zero;
  logic           w_row_end;
  logic           w_last;
  logic           w_drain_end;
  logic           w_busy;
  logic           w_done;
  logic           w_scan;
  logic           w_drain;
  logic [X_W:0]   w_sx;
  logic [Y_W:0]   w_sy;
  logic           w_v0;

  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_zero      = (i_rect_w == '0) || (i_rect_h == '0);
  assign w_row_end   = (r_cx == r_w - WW'(1));
  assign w_last      = w_row_end && (r_cy == r_h - HW'(1));
  // The drain covers the read latency plus one settling cycle.
  assign w_drain_end = (r_dcnt == DW'(RD_LAT));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = w_zero ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (w_last) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_end) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_scan  = 1'b0;
    w_drain = 1'b0;
    unique case (r_state)
      S_IDLE:  ;
      S_SCAN:  begin w_busy = 1'b1; w_scan = 1'b1; end
      S_DRAIN: begin w_busy = 1'b1; w_drain = 1'b1; end
      S_DONE:  begin w_busy = 1'b1; w_done = 1'b1; end
      default: ;
    endcase
  end

  assign o_busy = w_busy;
  assign o_done = w_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode  <= 1'b0;
      r_org_x <= '0;
      r_org_y <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_fill  <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_dcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_mode  <= i_mode;
        r_org_x <= i_org_x;
        r_org_y <= i_org_y;
        r_w     <= i_rect_w;
        r_h     <= i_rect_h;
        r_fill  <= i_fill_colour;
        r_cx    <= '0;
        r_cy    <= '0;
      end else if (w_scan) begin
        if (w_row_end) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
      r_dcnt <= w_drain ? r_dcnt + 1'b1 : '0;
    end
  end

  // One extra bit on each sum so off-screen pixels are detected, not wrapped.
  assign w_sx = (X_W+1)'(r_org_x) + (X_W+1)'(r_cx);
  assign w_sy = (Y_W+1)'(r_org_y) + (Y_W+1)'(r_cy);
  assign w_v0 = w_scan
             && (w_sx < (X_W+1)'(SCREEN_W))
             && (w_sy < (Y_W+1)'(SCREEN_H));

  assign o_bg_addr = ADDR_W'(w_sy) * ADDR_W'(SCREEN_W)
                   + ADDR_W'(w_sx);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_dx[i] <= '0;
        r_dy[i] <= '0;
        r_dv[i] <= 1'b0;
      end
    end else begin
      r_dx[0] <= w_sx[X_W-1:0];
      r_dy[0] <= w_sy[Y_W-1:0];
      r_dv[0] <= w_v0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_dx[i] <= r_dx[i-1];
        r_dy[i] <= r_dy[i-1];
        r_dv[i] <= r_dv[i-1];
      end
    end
  end

  assign o_vga_x      = r_dx[RD_LAT-1];
  assign o_vga_y      = r_dy[RD_LAT-1];
  assign o_vga_plot   = r_dv[RD_LAT-1];
  assign o_vga_colour = r_dv[RD_LAT-1]
                      ? (r_mode ? r_fill : i_bg_q) : '0;

endmodule

// File: tb/tb_region_restore_engine.sv
// tb_region_restore_engine: three engines (read latency 1, 2, 3) share
// stimulus; each is checked against a raster model of the rectangle.
`timescale 1ns/1ps
module tb_region_restore_engine;

  localparam int NL = 3;

  typedef struct {
    int rel;
    int x;
    int y;
    int c;
  } plot_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] org_x = '0;
  logic [6:0] org_y = '0;
  logic [5:0] rw = '0;
  logic [5:0] rh = '0;
  logic [8:0] fill = '0;

  logic [14:0] addr [NL];
  logic [8:0]  q    [NL];
  logic        bsy  [NL];
  logic        dn   [NL];
  logic        vp   [NL];
  logic [7:0]  vx   [NL];
  logic [6:0]  vy   [NL];
  logic [8:0]  vc   [NL];
  logic [14:0] apipe [NL][NL];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  plot_t obs [NL][$];
  int done_rel [NL];
  int done_cnt [NL];
  int busy_cnt [NL];
  int busy_first [NL];
  int busy_last [NL];
  plot_t exp_q [$];
  int exp_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    region_restore_engine #(.RD_LAT(g + 1)) u_dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_start      (start),
      .i_mode       (mode),
      .i_org_x      (org_x),
      .i_org_y      (org_y),
      .i_rect_w     (rw),
      .i_rect_h     (rh),
      .i_fill_colour(fill),
      .o_bg_addr    (addr[g]),
      .i_bg_q       (q[g]),
      .o_busy       (bsy[g]),
      .o_done       (dn[g]),
      .o_vga_x      (vx[g]),
      .o_vga_y      (vy[g]),
      .o_vga_colour (vc[g]),
      .o_vga_plot   (vp[g])
    );
  end

  // Background RAM: q = addr[8:0], delayed by each engine's latency.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      apipe[i][0] <= addr[i];
      for (int j = 1; j < NL; j++) apipe[i][j] <= apipe[i][j-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NL; i++) q[i] = apipe[i][i][8:0];
  end

  // Expected plots: raster walk, drop off-screen pixels.
  task automatic build_exp(input int ox, input int oy, input int w,
                           input int h, input int md, input int fc,
                           input int lat);
    plot_t p;
    int n;
    n = w * h;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      p.x = ox + k % w;
      p.y = oy + k / w;
      if (p.x < 160 && p.y < 120) begin
        p.rel = k + lat;
        p.c = md ? fc : (p.y * 160 + p.x) % 512;
        exp_q.push_back(p);
      end
    end
    exp_done = (n == 0) ? 0 : n + lat + 1;
  endtask

  // Issue one request and record everything the engines do afterwards.
  task automatic run_op(input int ox, input int oy, input int w,
                        input int h, input int md, input int fc,
                        input bit disturb, input int window);
    plot_t p;
    @(negedge clk);
    org_x = 8'(ox); org_y = 7'(oy);
    rw = 6'(w); rh = 6'(h);
    mode = md[0]; fill = 9'(fc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NL; i++) begin
      obs[i].delete();
      done_rel[i] = -1; done_cnt[i] = 0;
      busy_cnt[i] = 0; busy_first[i] = -1; busy_last[i] = -1;
    end
    for (int r = 0; r < window; r++) begin
      for (int i = 0; i < NL; i++) begin
        if (vp[i]) begin
          p.rel = r; p.x = int'(vx[i]);
          p.y = int'(vy[i]); p.c = int'(vc[i]);
          obs[i].push_back(p);
        end
        if (dn[i]) begin done_cnt[i]++; done_rel[i] = r; end
        if (bsy[i]) begin
          if (busy_cnt[i] == 0) busy_first[i] = r;
          busy_cnt[i]++;
          busy_last[i] = r;
        end
      end
      if (disturb && r == 100) begin
        start = 1'b1; org_x = org_x + 8'd37;
        mode = ~mode; fill = ~fill;
      end
      if (disturb && r == 101) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      n_assert++;
      if ({bsy[i], dn[i], vp[i]} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ctrl lat%0d busy/done/plot got %b%b%b expected 000",
                 i + 1, bsy[i], dn[i], vp[i]);
      end
      n_assert++;
      if (addr[i] !== 0 || vx[i] !== 0 || vy[i] !== 0 || vc[i] !== 0) begin
        n_fail++;
        $display("FAIL reset_data lat%0d addr=%0d x=%0d y=%0d c=%0d expected all 0",
                 i + 1, addr[i], vx[i], vy[i], vc[i]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      n_assert++;
      if (bsy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_busy lat%0d got %b expected 0", i + 1, bsy[i]);
      end
    end
  endtask

  task automatic test_zero_size();
    int ws [2] = '{0, 7};
    int hs [2] = '{5, 0};
    for (int s = 0; s < 2; s++) begin
      run_op(3, 4, ws[s], hs[s], 0, 0, 1'b0, 6);
      for (int i = 0; i < NL; i++) begin
        n_assert++;
        if (obs[i].size() != 0 || done_cnt[i] !== 1 || done_rel[i] !== 0
            || busy_cnt[i] !== 1) begin
          n_fail++;
          $display("FAIL zero_size%0d lat%0d plots=%0d done=%0d@%0d busy=%0d expected 0 1@0 1",
                   s, i + 1, obs[i].size(), done_cnt[i], done_rel[i], busy_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_start_held();
    bit eb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit ed [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rw = 6'd0; rh = 6'd1; start = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (r == 2) start = 1'b0;
      for (int i = 0; i < NL; i++) begin
        n_assert++;
        if (bsy[i] !== eb[r] || dn[i] !== ed[r]) begin
          n_fail++;
          $display("FAIL start_held lat%0d rel%0d busy/done got %b%b expected %b%b",
                   i + 1, r, bsy[i], dn[i], eb[r], ed[r]);
        end
      end
    end
  endtask

  task automatic test_scenarios();
    string t_nm [4] = '{"restore", "clip", "fill", "ignore_inputs"};
    int t_ox [4] = '{10, 150, 0, 10};
    int t_oy [4] = '{5, 110, 0, 5};
    int t_w  [4] = '{20, 20, 3, 20};
    int t_h  [4] = '{20, 20, 2, 20};
    int t_md [4] = '{0, 0, 1, 0};
    int t_fc [4] = '{0, 0, 448, 0};
    bit t_ds [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      run_op(t_ox[s], t_oy[s], t_w[s], t_h[s], t_md[s], t_fc[s],
             t_ds[s], t_w[s] * t_h[s] + 10);
      for (int i = 0; i < NL; i++) begin
        build_exp(t_ox[s], t_oy[s], t_w[s], t_h[s], t_md[s], t_fc[s], i + 1);
        n_assert++;
        if (obs[i].size() != exp_q.size()) begin
          n_fail++;
          $display("FAIL %s lat%0d plot_count got %0d expected %0d",
                   t_nm[s], i + 1, obs[i].size(), exp_q.size());
        end else begin
          for (int j = 0; j < exp_q.size(); j++) begin
            n_assert++;
            if (obs[i][j].rel !== exp_q[j].rel || obs[i][j].x !== exp_q[j].x
                || obs[i][j].y !== exp_q[j].y || obs[i][j].c !== exp_q[j].c) begin
              n_fail++;
              $display("FAIL %s lat%0d plot%0d got t%0d (%0d,%0d) c%0d expected t%0d (%0d,%0d) c%0d",
                       t_nm[s], i + 1, j, obs[i][j].rel, obs[i][j].x, obs[i][j].y,
                       obs[i][j].c, exp_q[j].rel, exp_q[j].x, exp_q[j].y, exp_q[j].c);
            end
          end
        end
        n_assert++;
        if (done_cnt[i] !== 1 || done_rel[i] !== exp_done) begin
          n_fail++;
          $display("FAIL %s lat%0d done got %0d pulses @%0d expected 1 @%0d",
                   t_nm[s], i + 1, done_cnt[i], done_rel[i], exp_done);
        end
        n_assert++;
        if (busy_cnt[i] !== exp_done + 1 || busy_first[i] !== 0
            || busy_last[i] !== exp_done) begin
          n_fail++;
          $display("FAIL %s lat%0d busy got %0d cycles %0d..%0d expected 0..%0d",
                   t_nm[s], i + 1, busy_cnt[i], busy_first[i], busy_last[i], exp_done);
        end
      end
      if (s == 0) begin
        n_assert++;
        if (obs[1].size() != 400) begin
          n_fail++;
          $display("FAIL restore_anchor plots got %0d expected 400", obs[1].size());
        end else if (obs[1][0].c !== 298 || obs[1][0].x !== 10
                     || obs[1][399].x !== 29 || obs[1][399].y !== 24
                     || done_rel[1] !== 403) begin
          n_fail++;
          $display("FAIL restore_anchor got c0=%0d x0=%0d last=(%0d,%0d) done=%0d expected 298 10 (29,24) 403",
                   obs[1][0].c, obs[1][0].x, obs[1][399].x, obs[1][399].y, done_rel[1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    int viol [NL];
    @(negedge clk);
    org_x = 8'd10; org_y = 7'd5; rw = 6'd20; rh = 6'd20;
    mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int r = 0; r < 200 && cnt < 50; r++) begin
      if (vp[1]) cnt++;
      if (cnt < 50) @(negedge clk);
    end
    n_assert++;
    if (cnt != 50) begin
      n_fail++;
      $display("FAIL reset_mid_reach plots got %0d expected 50", cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NL; i++) viol[i] = 0;
    for (int r = 0; r < 420; r++) begin
      for (int i = 0; i < NL; i++)
        if (vp[i] || dn[i] || bsy[i]) viol[i]++;
      @(negedge clk);
    end
    for (int i = 0; i < NL; i++) begin
      n_assert++;
      if (viol[i] != 0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet lat%0d active cycles got %0d expected 0",
                 i + 1, viol[i]);
      end
    end
    run_op(10, 5, 20, 20, 0, 0, 1'b0, 410);
    for (int i = 0; i < NL; i++) begin
      build_exp(10, 5, 20, 20, 0, 0, i + 1);
      n_assert++;
      if (obs[i].size() != exp_q.size() || done_cnt[i] !== 1
          || done_rel[i] !== exp_done || busy_cnt[i] !== exp_done + 1) begin
        n_fail++;
        $display("FAIL reset_mid_restart lat%0d plots=%0d done=%0d@%0d busy=%0d expected %0d 1@%0d %0d",
                 i + 1, obs[i].size(), done_cnt[i], done_rel[i], busy_cnt[i],
                 exp_q.size(), exp_done, exp_done + 1);
      end
    end
  endtask

  task automatic test_random();
    int ox, oy, w, h, md, fc;
    for (int n = 0; n < 12; n++) begin
      ox = ($urandom_range(0, 2) == 0) ? $urandom_range(130, 159)
                                       : $urandom_range(0, 159);
      oy = ($urandom_range(0, 2) == 0) ? $urandom_range(95, 119)
                                       : $urandom_range(0, 119);
      w = $urandom_range(0, 32);
      h = $urandom_range(0, 32);
      md = $urandom_range(0, 1);
      fc = $urandom_range(0, 511);
      run_op(ox, oy, w, h, md, fc, 1'b0, w * h + 10);
      for (int i = 0; i < NL; i++) begin
        build_exp(ox, oy, w, h, md, fc, i + 1);
        n_assert++;
        if (obs[i].size() != exp_q.size()) begin
          n_fail++;
          $display("FAIL random%0d lat%0d plot_count got %0d expected %0d",
                   n, i + 1, obs[i].size(), exp_q.size());
        end else begin
          for (int j = 0; j < exp_q.size(); j++) begin
            n_assert++;
            if (obs[i][j].rel !== exp_q[j].rel || obs[i][j].x !== exp_q[j].x
                || obs[i][j].y !== exp_q[j].y || obs[i][j].c !== exp_q[j].c) begin
              n_fail++;
              $display("FAIL random%0d lat%0d plot%0d got t%0d (%0d,%0d) c%0d expected t%0d (%0d,%0d) c%0d",
                       n, i + 1, j, obs[i][j].rel, obs[i][j].x, obs[i][j].y,
                       obs[i][j].c, exp_q[j].rel, exp_q[j].x, exp_q[j].y, exp_q[j].c);
            end
          end
        end
        n_assert++;
        if (done_cnt[i] !== 1 || done_rel[i] !== exp_done
            || busy_cnt[i] !== exp_done + 1 || busy_first[i] !== 0) begin
          n_fail++;
          $display("FAIL random%0d lat%0d done/busy got %0d@%0d busy %0d from %0d expected 1@%0d busy %0d from 0",
                   n, i + 1, done_cnt[i], done_rel[i], busy_cnt[i], busy_first[i],
                   exp_done, exp_done + 1);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_zero_size();
    test_start_held();
    test_scenarios();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
